dispatch_in_order: RTL and testbench

- Counterpart to put_in_order at the opposite end of a parallel-lane datapath.
- Takes one in-order upstream stream and hands items to n_inputs parallel variable-latency lanes in strict round-robin order (lane 0, 1, …, n_inputs-1, 0, …). This is the order put_in_order relies on to reassemble results.
- Per-lane credit counters bound the outstanding items in each lane. A single output register per lane decouples lane back-pressure.

---
 rtl/dispatch_in_order_if.sv | 28 ++
 rtl/dispatch_in_order.sv | 97 +++++++++
 tb/tb_dispatch_in_order.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_in_order_if.sv
// Handshake bundle between an in-order producer, the round-robin dispatcher
// and its parallel lanes (up stream in, per-lane streams and credit returns out).
interface dispatch_in_order_if #(
    parameter int width    = 16,
    parameter int n_inputs = 4
);
    localparam int PW = $clog2(n_inputs);

    logic                           up_vld;
    logic                           up_rdy;
    logic [width-1:0]               up_data;
    logic [n_inputs-1:0]            down_vlds;
    logic [n_inputs-1:0]            down_rdys;
    logic [n_inputs-1:0][width-1:0] down_data;
    logic [n_inputs-1:0]            down_rets;
    logic [PW-1:0]                  dispatch_ptr;
    logic                           credit_err;

    modport master (
        output up_vld, up_data, down_rdys, down_rets,
        input  up_rdy, down_vlds, down_data, dispatch_ptr, credit_err
    );

    modport slave (
        input  up_vld, up_data, down_rdys, down_rets,
        output up_rdy, down_vlds, down_data, dispatch_ptr, credit_err
    );
endinterface

// File: rtl/dispatch_in_order.sv
// Round-robin dispatcher: feeds one in-order stream into n_inputs lanes in strict
// lane order, bounding each lane's outstanding work with a credit counter.
module dispatch_in_order #(
    parameter int width       = 16,
    parameter int n_inputs    = 4,
    parameter int max_credits = 2
) (
    input  logic               clk,
    input  logic               rst,
    dispatch_in_order_if.slave bus
);
    localparam int PW = $clog2(n_inputs);
    localparam int CW = $clog2(max_credits + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(max_credits);
    localparam logic [PW-1:0] PTR_LAST = PW'(n_inputs - 1);

    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [n_inputs-1:0][CW-1:0]    credits_q, credits_d;
    logic [n_inputs-1:0]            vld_q, vld_d;
    logic [n_inputs-1:0][width-1:0] data_q, data_d;
    logic                           err_q, err_d;
    logic                           up_rdy_s;
    logic                           accept_s;
    logic [n_inputs-1:0]            load_s;

    // Never skip a lane: only the pointed lane's credit and register matter.
    assign up_rdy_s = !rst && (credits_q[ptr_q] != '0)
                      && (!vld_q[ptr_q] || bus.down_rdys[ptr_q]);
    assign accept_s = bus.up_vld && up_rdy_s;

    // Next-state for pointer, lane registers, credits and the sticky error flag.
    always_comb begin
        ptr_d     = ptr_q;
        credits_d = credits_q;
        vld_d     = vld_q;
        data_d    = data_q;
        err_d     = err_q;
        load_s    = '0;

        if (accept_s) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end

        for (int i = 0; i < n_inputs; i++) begin
            load_s[i] = accept_s && (ptr_q == PW'(i));

            if (load_s[i]) begin
                vld_d[i]  = 1'b1;
                data_d[i] = bus.up_data;
            end else if (bus.down_rdys[i]) begin
                vld_d[i]  = 1'b0;
                data_d[i] = data_q[i];
            end else begin
                vld_d[i]  = vld_q[i];
                data_d[i] = data_q[i];
            end

            // A return alongside a load cancels out; a return into a full lane is an error.
            case ({bus.down_rets[i], load_s[i]})
                2'b10: begin
                    if (credits_q[i] == CRED_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        credits_d[i] = credits_q[i] + CW'(1);
                    end
                end
                2'b01:   credits_d[i] = credits_q[i] - CW'(1);
                default: credits_d[i] = credits_q[i];
            endcase
        end
    end

    // State registers; reset discards in-flight lane contents and refills credits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            credits_q <= {n_inputs{CRED_MAX}};
            vld_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign bus.up_rdy       = up_rdy_s;
    assign bus.down_vlds    = vld_q;
    assign bus.down_data    = data_q;
    assign bus.dispatch_ptr = ptr_q;
    assign bus.credit_err   = err_q;
endmodule

// File: tb/tb_dispatch_in_order.sv
// Scoreboard bench for dispatch_in_order: a queue-per-lane reference model predicts
// ready, pointer, lane contents and the error flag; directed scenarios plus random traffic.
module tb_dispatch_in_order;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MC = 2;

    logic clk = 1'b0;
    logic rst;

    dispatch_in_order_if #(.width(W), .n_inputs(N)) bus ();

    dispatch_in_order #(.width(W), .n_inputs(N), .max_credits(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: items waiting in each lane register, credits, accept count.
    logic [W-1:0] exp_q [N][$];
    int           cred [N];
    int           acc_cnt;
    bit           err_m;
    int           outstanding [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            cred[i]        = MC;
            outstanding[i] = 0;
        end
        acc_cnt = 0;
        err_m   = 1'b0;
    endtask

    // Monitor: compare each lane against the head of its expected queue, pop on drain.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("lane%0d_vld", i), 64'(bus.down_vlds[i]), 64'(exp_q[i].size() != 0));
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("lane%0d_data", i), 64'(bus.down_data[i]), 64'(exp_q[i][0]));
                    if (bus.down_rdys[i]) begin
                        void'(exp_q[i].pop_front());
                        outstanding[i]++;
                    end
                end
            end
        end
    end

    // Model step: predict ready/pointer/error, then apply this cycle's accept and returns.
    always begin : model_step
        int p;
        bit rdy_m;
        bit acc;
        @(negedge clk);
        #2;
        if (rst) begin
            model_reset();
            chk("up_rdy_in_reset", 64'(bus.up_rdy), 64'(0));
        end else begin
            p     = acc_cnt % N;
            rdy_m = (cred[p] > 0) && (exp_q[p].size() == 0);
            acc   = bus.up_vld && rdy_m;
            chk("up_rdy", 64'(bus.up_rdy), 64'(rdy_m));
            chk("dispatch_ptr", 64'(bus.dispatch_ptr), 64'(p));
            chk("credit_err", 64'(bus.credit_err), 64'(err_m));
            for (int i = 0; i < N; i++) begin
                if (bus.down_rets[i] && !(acc && i == p)) begin
                    if (cred[i] == MC) err_m = 1'b1;
                    else               cred[i]++;
                end
            end
            if (acc) begin
                exp_q[p].push_back(bus.up_data);
                acc_cnt++;
                if (!bus.down_rets[p]) cred[p]--;
            end
        end
    end

    // Offer consecutive items starting at 'first'; returns how many were accepted.
    task automatic send(input logic [W-1:0] first, input int count, input int budget,
                        input logic [N-1:0] rets_first, output int n);
        logic [W-1:0] d;
        d = first;
        n = 0;
        for (int c = 0; c < budget && n < count; c++) begin
            @(negedge clk);
            bus.up_vld    = 1'b1;
            bus.up_data   = d;
            bus.down_rets = (c == 0) ? rets_first : '0;
            #3;
            if (bus.up_rdy) begin
                n++;
                d = d + 16'd1;
            end
        end
        @(negedge clk);
        bus.up_vld    = 1'b0;
        bus.down_rets = '0;
    endtask

    task automatic idle(input int cycles, input logic [N-1:0] rets);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            bus.up_vld    = 1'b0;
            bus.down_rets = (c == 0) ? rets : '0;
        end
        @(negedge clk);
        bus.down_rets = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [N-1:0] r;
        rst           = 1'b1;
        bus.up_vld    = 1'b0;
        bus.up_data   = '0;
        bus.down_rdys = '0;
        bus.down_rets = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("rst_vlds", 64'(bus.down_vlds), 64'(0));
        chk("rst_data", 64'(bus.down_data), 64'(0));
        chk("rst_ptr", 64'(bus.dispatch_ptr), 64'(0));
        chk("rst_err", 64'(bus.credit_err), 64'(0));
        chk("rst_up_rdy", 64'(bus.up_rdy), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Streaming until every lane is out of credit
        bus.down_rdys = '1;
        send(16'd0, 8, 8, 4'b0000, n);
        chk("s1_accepts", 64'(n), 64'(8));
        #3;
        chk("s1_stalled", 64'(bus.up_rdy), 64'(0));
        chk("s1_ptr", 64'(bus.dispatch_ptr), 64'(0));

        // Credit on lane 1 alone cannot unblock lane 0
        idle(1, 4'b0010);
        bus.up_vld  = 1'b1;
        bus.up_data = 16'd8;
        #3;
        chk("s2_still_stalled", 64'(bus.up_rdy), 64'(0));
        send(16'd8, 2, 6, 4'b0001, n);
        chk("s2_accepts", 64'(n), 64'(2));
        #3;
        chk("s2_ptr", 64'(bus.dispatch_ptr), 64'(2));

        // Lane 2 held by back-pressure, then drain and load in the same cycle
        do_reset();
        bus.down_rdys = '1;
        send(16'd0, 6, 6, 4'b0000, n);
        bus.down_rdys = 4'b1011;
        send(16'd6, 2, 4, 4'b0000, n);
        idle(1, 4'b0011);
        send(16'd8, 2, 4, 4'b0000, n);
        idle(2, 4'b0100);
        #3;
        chk("s3_blocked", 64'(bus.up_rdy), 64'(0));
        chk("s3_held_vld", 64'(bus.down_vlds[2]), 64'(1));
        chk("s3_held_data", 64'(bus.down_data[2]), 64'(16'h0006));
        @(negedge clk);
        bus.down_rdys = '1;
        bus.up_vld    = 1'b1;
        bus.up_data   = 16'h000a;
        #3;
        chk("s3_rdy_on_drain", 64'(bus.up_rdy), 64'(1));
        @(negedge clk);
        bus.up_vld = 1'b0;
        #3;
        chk("s3_reload_vld", 64'(bus.down_vlds[2]), 64'(1));
        chk("s3_reload_data", 64'(bus.down_data[2]), 64'(16'h000a));

        // Accept and credit return on the same lane in the same cycle
        do_reset();
        bus.down_rdys = '1;
        send(16'd0, 4, 4, 4'b0000, n);
        send(16'd4, 1, 2, 4'b0001, n);
        chk("s4_accept", 64'(n), 64'(1));
        #3;
        chk("s4_no_err", 64'(bus.credit_err), 64'(0));
        send(16'd5, 4, 6, 4'b0000, n);
        chk("s4_lane0_credit_kept", 64'(n), 64'(4));

        // Random traffic with legal credit returns
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.up_vld    = ($urandom_range(3) != 0);
            bus.up_data   = W'($urandom);
            bus.down_rdys = N'($urandom) | N'($urandom);
            for (int i = 0; i < N; i++) begin
                r[i] = (outstanding[i] > 0) && ($urandom_range(2) == 0);
                if (r[i]) outstanding[i]--;
            end
            bus.down_rets = r;
        end
        @(negedge clk);
        bus.up_vld    = 1'b0;
        bus.down_rets = '0;
        bus.down_rdys = '1;
        repeat (3) @(negedge clk);

        // Asynchronous reset between edges with three lanes occupied
        do_reset();
        bus.down_rdys = '0;
        send(16'd0, 3, 3, 4'b0000, n);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("s6_vlds_cleared", 64'(bus.down_vlds), 64'(0));
        chk("s6_ptr", 64'(bus.dispatch_ptr), 64'(0));
        chk("s6_up_rdy", 64'(bus.up_rdy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.down_rdys = '1;
        send(16'd100, 9, 10, 4'b0000, n);
        chk("s6_accepts_after_reset", 64'(n), 64'(8));

        // Spurious credit return into a full lane sets the sticky error
        do_reset();
        bus.down_rdys = '1;
        idle(3, 4'b1000);
        #3;
        chk("s5_err_set", 64'(bus.credit_err), 64'(1));
        send(16'd200, 8, 8, 4'b0000, n);
        chk("s5_credits_kept", 64'(n), 64'(8));
        #3;
        chk("s5_err_sticky", 64'(bus.credit_err), 64'(1));
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
